// File: rtl/sr_ctx_ctrl.sv
// Special-register file write-port owner with context save/restore to data memory.
// Save streams every SR out through read port 2; restore reloads them one read at a time.
module sr_ctx_ctrl #(
   parameter int SR_COUNT = 16,
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 24,
   parameter int MADDR_W  = 24
) (
   input  logic               iw_clk,
   input  logic               iw_rst,
   input  logic               iw_save_start,
   input  logic               iw_restore_start,
   input  logic [MADDR_W-1:0] iw_base_addr,
   input  logic               iw_wb_valid,
   input  logic [ADDR_W-1:0]  iw_wb_addr,
   input  logic [DATA_W-1:0]  iw_wb_data,
   output logic               ow_wb_ready,
   input  logic [ADDR_W-1:0]  iw_pipe_rd_addr2,
   output logic [ADDR_W-1:0]  ow_sr_read_addr2,
   input  logic [DATA_W-1:0]  iw_sr_read_data2,
   output logic               ow_sr_write_enable,
   output logic [ADDR_W-1:0]  ow_sr_write_addr,
   output logic [DATA_W-1:0]  ow_sr_write_data,
   output logic               ow_mem_req_valid,
   output logic               ow_mem_req_we,
   output logic [MADDR_W-1:0] ow_mem_req_addr,
   output logic [DATA_W-1:0]  ow_mem_req_data,
   input  logic               iw_mem_req_ready,
   input  logic               iw_mem_rsp_valid,
   input  logic [DATA_W-1:0]  iw_mem_rsp_data,
   output logic               ow_busy,
   output logic               ow_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAVE,
      S_RD_REQ,
      S_RD_WAIT,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    r_idx_q, r_idx_d;
   logic [MADDR_W-1:0]   r_base_q, r_base_d;
   logic                 last_idx;
   logic [MADDR_W-1:0]   req_addr;

   assign last_idx = (r_idx_q == ADDR_W'(SR_COUNT - 1));
   assign req_addr = r_base_q + MADDR_W'(r_idx_q);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      r_idx_d  = r_idx_q;
      r_base_d = r_base_q;
      case (state_q)
         S_IDLE: begin
            // Save wins when both commands arrive together.
            if (iw_save_start) begin
               r_base_d = iw_base_addr;
               r_idx_d  = '0;
               state_d  = S_SAVE;
            end else if (iw_restore_start) begin
               r_base_d = iw_base_addr;
               r_idx_d  = '0;
               state_d  = S_RD_REQ;
            end
         end
         S_SAVE: begin
            if (iw_mem_req_ready) begin
               if (last_idx) state_d = S_DONE;
               else          r_idx_d = r_idx_q + ADDR_W'(1);
            end
         end
         S_RD_REQ: begin
            if (iw_mem_req_ready) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (iw_mem_rsp_valid) begin
               if (last_idx) begin
                  state_d = S_DONE;
               end else begin
                  r_idx_d = r_idx_q + ADDR_W'(1);
                  state_d = S_RD_REQ;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state_q  <= S_IDLE;
         r_idx_q  <= '0;
         r_base_q <= '0;
      end else begin
         state_q  <= state_d;
         r_idx_q  <= r_idx_d;
         r_base_q <= r_base_d;
      end
   end

   always_comb begin
      ow_wb_ready        = (state_q == S_IDLE);
      ow_busy            = (state_q != S_IDLE);
      ow_done            = (state_q == S_DONE);
      ow_sr_read_addr2   = iw_pipe_rd_addr2;
      ow_sr_write_enable = 1'b0;
      ow_sr_write_addr   = iw_wb_addr;
      ow_sr_write_data   = iw_wb_data;
      ow_mem_req_valid   = 1'b0;
      ow_mem_req_we      = 1'b0;
      ow_mem_req_addr    = '0;
      ow_mem_req_data    = '0;
      case (state_q)
         S_IDLE: ow_sr_write_enable = iw_wb_valid;
         S_SAVE: begin
            // Read port 2 feeds the memory write data combinationally.
            ow_sr_read_addr2 = r_idx_q;
            ow_mem_req_valid = 1'b1;
            ow_mem_req_we    = 1'b1;
            ow_mem_req_addr  = req_addr;
            ow_mem_req_data  = iw_sr_read_data2;
         end
         S_RD_REQ: begin
            ow_mem_req_valid = 1'b1;
            ow_mem_req_addr  = req_addr;
         end
         S_RD_WAIT: begin
            ow_sr_write_enable = iw_mem_rsp_valid;
            ow_sr_write_addr   = r_idx_q;
            ow_sr_write_data   = iw_mem_rsp_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sr_ctx_ctrl.sv
// Directed bench for sr_ctx_ctrl: SR-file and memory models, request/write/done logs,
// hand-derived expectations for pass-through, save, stalled save, restore, collisions and reset.
module tb_sr_ctx_ctrl;
   localparam int SR_COUNT = 16;
   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 24;
   localparam int MADDR_W  = 24;

   logic               iw_clk = 1'b0;
   logic               iw_rst;
   logic               iw_save_start, iw_restore_start;
   logic [MADDR_W-1:0] iw_base_addr;
   logic               iw_wb_valid;
   logic [ADDR_W-1:0]  iw_wb_addr;
   logic [DATA_W-1:0]  iw_wb_data;
   logic               ow_wb_ready;
   logic [ADDR_W-1:0]  iw_pipe_rd_addr2, ow_sr_read_addr2;
   logic [DATA_W-1:0]  iw_sr_read_data2;
   logic               ow_sr_write_enable;
   logic [ADDR_W-1:0]  ow_sr_write_addr;
   logic [DATA_W-1:0]  ow_sr_write_data;
   logic               ow_mem_req_valid, ow_mem_req_we;
   logic [MADDR_W-1:0] ow_mem_req_addr;
   logic [DATA_W-1:0]  ow_mem_req_data;
   logic               iw_mem_req_ready, iw_mem_rsp_valid;
   logic [DATA_W-1:0]  iw_mem_rsp_data;
   logic               ow_busy, ow_done;

   sr_ctx_ctrl #(.SR_COUNT(SR_COUNT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MADDR_W(MADDR_W)) dut (
      .iw_clk(iw_clk), .iw_rst(iw_rst),
      .iw_save_start(iw_save_start), .iw_restore_start(iw_restore_start),
      .iw_base_addr(iw_base_addr),
      .iw_wb_valid(iw_wb_valid), .iw_wb_addr(iw_wb_addr), .iw_wb_data(iw_wb_data),
      .ow_wb_ready(ow_wb_ready),
      .iw_pipe_rd_addr2(iw_pipe_rd_addr2), .ow_sr_read_addr2(ow_sr_read_addr2),
      .iw_sr_read_data2(iw_sr_read_data2),
      .ow_sr_write_enable(ow_sr_write_enable), .ow_sr_write_addr(ow_sr_write_addr),
      .ow_sr_write_data(ow_sr_write_data),
      .ow_mem_req_valid(ow_mem_req_valid), .ow_mem_req_we(ow_mem_req_we),
      .ow_mem_req_addr(ow_mem_req_addr), .ow_mem_req_data(ow_mem_req_data),
      .iw_mem_req_ready(iw_mem_req_ready), .iw_mem_rsp_valid(iw_mem_rsp_valid),
      .iw_mem_rsp_data(iw_mem_rsp_data),
      .ow_busy(ow_busy), .ow_done(ow_done)
   );

   always #5 iw_clk = ~iw_clk;

   int cyc = 0;
   always @(posedge iw_clk) cyc <= cyc + 1;

   // SR file model: combinational read port 2, registered write port, bulk preload.
   logic [DATA_W-1:0] sr_file [SR_COUNT];
   logic              init_file;
   assign iw_sr_read_data2 = sr_file[ow_sr_read_addr2];
   always @(posedge iw_clk) begin
      if (init_file) begin
         for (int i = 0; i < SR_COUNT; i++) sr_file[i] <= DATA_W'(i * 17);
      end else if (ow_sr_write_enable) begin
         sr_file[ow_sr_write_addr] <= ow_sr_write_data;
      end
   end

   // Memory model: ready low inside [stall_lo, stall_hi], read data one cycle after acceptance.
   int stall_lo = 32'h7fff_0000;
   int stall_hi = 32'h7fff_0000;
   logic              rsp_v;
   logic [DATA_W-1:0] rsp_d;
   assign iw_mem_req_ready = !(cyc >= stall_lo && cyc <= stall_hi);
   assign iw_mem_rsp_valid = rsp_v;
   assign iw_mem_rsp_data  = rsp_d;
   always @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         rsp_v <= 1'b0;
         rsp_d <= '0;
      end else begin
         rsp_v <= ow_mem_req_valid && iw_mem_req_ready && !ow_mem_req_we;
         rsp_d <= 24'hF00000 + (ow_mem_req_addr - 24'h000200);
      end
   end

   typedef struct {
      int          cyc;
      logic [23:0] addr;
      logic [23:0] data;
      logic        we;
      logic        rdy;
   } ev_t;

   ev_t  req_log[$];
   ev_t  wr_log[$];
   int   done_log[$];
   int   busy_log[$];
   ev_t  mon_e;

   always @(negedge iw_clk) begin
      if (ow_mem_req_valid) begin
         mon_e.cyc = cyc; mon_e.addr = ow_mem_req_addr; mon_e.data = ow_mem_req_data;
         mon_e.we = ow_mem_req_we; mon_e.rdy = iw_mem_req_ready;
         req_log.push_back(mon_e);
      end
      if (ow_sr_write_enable) begin
         mon_e.cyc = cyc; mon_e.addr = 24'(ow_sr_write_addr); mon_e.data = ow_sr_write_data;
         mon_e.we = 1'b1; mon_e.rdy = 1'b1;
         wr_log.push_back(mon_e);
      end
      if (ow_done) done_log.push_back(cyc);
      if (ow_busy) busy_log.push_back(cyc);
   end

   int n_checks = 0;
   int n_pass   = 0;
   logic [23:0] exp_sr [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge iw_clk);
      #1;
   endtask

   task automatic wait_done(input int n0, input int budget);
      int k;
      k = 0;
      while (done_log.size() == n0 && k < budget) begin
         tick();
         k++;
      end
      check("done_seen", 32'(done_log.size() > n0), 32'd1);
   endtask

   // Walks logged requests from r0: counts accepted ones and field errors against base/exp_sr.
   task automatic scan_reqs(input int r0, input logic [23:0] base, input logic exp_we,
                            output int acc, output int errs);
      acc  = 0;
      errs = 0;
      for (int i = r0; i < req_log.size(); i++) begin
         if (req_log[i].we !== exp_we) errs++;
         if (req_log[i].rdy) begin
            if (req_log[i].addr !== base + 24'(acc)) errs++;
            if (exp_we && req_log[i].data !== exp_sr[acc % 16]) errs++;
            acc++;
         end
      end
   endtask

   task automatic pulse_cmd(input logic save, input logic restore, input logic [23:0] base,
                            output int t);
      iw_save_start    = save;
      iw_restore_start = restore;
      iw_base_addr     = base;
      t = cyc;
      tick();
      iw_save_start    = 1'b0;
      iw_restore_start = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t, r0, d0, b0, w0, acc, errs, nstall, rc, late;

      iw_rst = 1'b1; iw_save_start = 1'b0; iw_restore_start = 1'b0; iw_base_addr = '0;
      iw_wb_valid = 1'b0; iw_wb_addr = '0; iw_wb_data = '0; iw_pipe_rd_addr2 = '0;
      init_file = 1'b0;
      #12;
      check("rst_busy", ow_busy, 0);
      check("rst_done", ow_done, 0);
      check("rst_valid", ow_mem_req_valid, 0);
      check("rst_we", ow_mem_req_we, 0);
      check("rst_addr", ow_mem_req_addr, 0);
      check("rst_data", ow_mem_req_data, 0);
      check("rst_wb_ready", ow_wb_ready, 1);
      tick();
      iw_rst = 1'b0;
      tick();

      // Pass-through in IDLE
      iw_wb_valid = 1'b1; iw_wb_addr = 4'd3; iw_wb_data = 24'h00ABCD; iw_pipe_rd_addr2 = 4'd7;
      #1;
      check("pt_we", ow_sr_write_enable, 1);
      check("pt_waddr", ow_sr_write_addr, 3);
      check("pt_wdata", ow_sr_write_data, 24'h00ABCD);
      check("pt_ready", ow_wb_ready, 1);
      check("pt_raddr2", ow_sr_read_addr2, 7);
      tick();
      iw_wb_valid = 1'b0;
      check("pt_file3", sr_file[3], 24'h00ABCD);

      init_file = 1'b1; tick(); init_file = 1'b0;
      for (int i = 0; i < 16; i++) exp_sr[i] = 24'(i * 17);

      // Save, ready held high
      r0 = req_log.size(); d0 = done_log.size(); b0 = busy_log.size();
      pulse_cmd(1'b1, 1'b0, 24'h000100, t);
      wait_done(d0, 60);
      repeat (3) tick();
      scan_reqs(r0, 24'h000100, 1'b1, acc, errs);
      check("save_count", acc, 16);
      check("save_errs", errs, 0);
      check("save_cycles", req_log.size() - r0, 16);
      check("save_done_n", done_log.size() - d0, 1);
      check("save_done_t", done_log[d0] - t, 17);
      check("save_busy_n", busy_log.size() - b0, 17);
      check("save_busy_first", busy_log[b0] - t, 1);

      // Save with ready low for three cycles on index 5
      r0 = req_log.size(); d0 = done_log.size();
      stall_lo = cyc + 6; stall_hi = cyc + 8;
      pulse_cmd(1'b1, 1'b0, 24'h000100, t);
      wait_done(d0, 60);
      repeat (3) tick();
      stall_lo = 32'h7fff_0000; stall_hi = 32'h7fff_0000;
      scan_reqs(r0, 24'h000100, 1'b1, acc, errs);
      nstall = 0;
      for (int i = r0; i < req_log.size(); i++) begin
         if (!req_log[i].rdy) begin
            nstall++;
            if (req_log[i].addr !== 24'h000105 || req_log[i].data !== 24'h000055) errs++;
         end
      end
      check("stall_count", acc, 16);
      check("stall_held", nstall, 3);
      check("stall_errs", errs, 0);
      check("stall_done_t", done_log[d0] - t, 20);

      // Restore with a pipeline write held off until IDLE
      r0 = req_log.size(); d0 = done_log.size(); w0 = wr_log.size();
      pulse_cmd(1'b0, 1'b1, 24'h000200, t);
      iw_wb_valid = 1'b1; iw_wb_addr = 4'd9; iw_wb_data = 24'h123456;
      rc = -1;
      for (int k = 0; k < 80; k++) begin
         if (ow_wb_ready) begin
            rc = cyc;
            break;
         end
         tick();
      end
      tick();
      iw_wb_valid = 1'b0;
      check("rest_wb_ready_t", rc - t, 34);
      check("rest_done_t", (done_log.size() > d0) ? done_log[d0] - t : -1, 33);
      scan_reqs(r0, 24'h000200, 1'b0, acc, errs);
      check("rest_reqs", acc, 16);
      check("rest_req_errs", errs, 0);
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (w0 + i >= wr_log.size()) errs++;
         else if (wr_log[w0+i].addr !== 24'(i) || wr_log[w0+i].data !== 24'hF00000 + 24'(i)) errs++;
      end
      check("rest_wr_errs", errs, 0);
      check("rest_wr_n", wr_log.size() - w0, 17);
      check("rest_pipe_wr_t", (wr_log.size() > w0 + 16) ? wr_log[w0+16].cyc - t : -1, 34);
      check("rest_file9", sr_file[9], 24'h123456);
      check("rest_file15", sr_file[15], 24'hF0000F);

      // Save and restore together, then a stray restore mid-save
      init_file = 1'b1; tick(); init_file = 1'b0;
      r0 = req_log.size(); d0 = done_log.size();
      pulse_cmd(1'b1, 1'b1, 24'h000100, t);
      repeat (4) tick();
      iw_restore_start = 1'b1; tick(); iw_restore_start = 1'b0;
      wait_done(d0, 60);
      repeat (6) tick();
      scan_reqs(r0, 24'h000100, 1'b1, acc, errs);
      late = 0;
      for (int i = r0; i < req_log.size(); i++) if (req_log[i].cyc > t + 17) late++;
      check("both_count", acc, 16);
      check("both_errs", errs, 0);
      check("both_late_reqs", late, 0);
      check("both_done_n", done_log.size() - d0, 1);

      // Reset during restore at index 9
      d0 = done_log.size();
      pulse_cmd(1'b0, 1'b1, 24'h000200, t);
      repeat (18) tick();
      check("rr_idx9_addr", ow_mem_req_addr, 24'h000209);
      iw_rst = 1'b1;
      tick();
      check("rr_busy", ow_busy, 0);
      check("rr_valid", ow_mem_req_valid, 0);
      iw_rst = 1'b0;
      repeat (40) tick();
      check("rr_no_done", done_log.size() - d0, 0);
      for (int i = 0; i < 16; i++) exp_sr[i] = (i < 9) ? 24'hF00000 + 24'(i) : 24'(i * 17);
      r0 = req_log.size(); d0 = done_log.size();
      pulse_cmd(1'b1, 1'b0, 24'h000300, t);
      wait_done(d0, 60);
      repeat (2) tick();
      check("rr_first_addr", (req_log.size() > r0) ? req_log[r0].addr : 24'hFFFFFF, 24'h000300);
      check("rr_first_data", (req_log.size() > r0) ? req_log[r0].data : 24'hFFFFFF, 24'hF00000);
      scan_reqs(r0, 24'h000300, 1'b1, acc, errs);
      check("rr_save_count", acc, 16);
      check("rr_save_errs", errs, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
